// File: rtl/uart_bridge_pkg.sv
// Shared opcodes, reply codes and FSM state encoding for the UART command responder.
package uart_bridge_pkg;

    localparam logic [7:0] OP_WRITE = 8'h57;
    localparam logic [7:0] OP_READ  = 8'h52;
    localparam logic [7:0] RSP_ACK  = 8'h06;
    localparam logic [7:0] RSP_NAK  = 8'h15;

    typedef enum logic [2:0] {
        IDLE,
        ADDR,
        DATA,
        BUS,
        RESP
    } bridge_state_t;

endpackage

// File: rtl/uart_cmd_responder.sv
// Decodes framed read/write commands from a UART byte stream into single 32-bit bus
// accesses and streams back ACK/NAK or read data.
//   state | meaning
//   IDLE  | waiting for an opcode byte
//   ADDR  | collecting little-endian address bytes
//   DATA  | collecting 4 little-endian write data bytes
//   BUS   | bus access in flight
//   RESP  | sending reply bytes to uart tx
module uart_cmd_responder
    import uart_bridge_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 5_000_000,
    parameter int ADDR_W         = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [7:0]        rx_data,
    input  logic              rx_data_fresh,
    output logic [7:0]        tx_data,
    output logic              tx_data_valid,
    input  logic              tx_data_ack,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata,
    input  logic              mem_ready,
    output logic              err_pulse
);

    localparam int               ADDR_BYTES = ADDR_W / 8;
    localparam int               TMO_W      = $clog2(TIMEOUT_CYCLES);
    localparam logic [2:0]       LAST_ADDR  = 3'(ADDR_BYTES - 1);
    localparam logic [TMO_W-1:0] TMO_LOAD   = TMO_W'(TIMEOUT_CYCLES - 1);

    bridge_state_t     state, state_next;
    logic [7:0]        op;
    logic [2:0]        cnt;
    logic [TMO_W-1:0]  tmo;
    logic [ADDR_W-1:0] addr;
    logic [31:0]       wdata;
    logic [31:0]       resp;
    logic [1:0]        idx;
    logic [1:0]        last_idx;
    logic              err_next;
    logic              in_frame;
    logic              timeout_hit;
    logic              bus_done;
    logic              tx_done;

    // A byte arriving in the terminal cycle wins over the timeout.
    assign in_frame    = (state == ADDR) || (state == DATA);
    assign timeout_hit = in_frame && !rx_data_fresh && (tmo == '0);
    assign bus_done    = mem_req && mem_ready;
    assign tx_done     = tx_data_valid && tx_data_ack && (idx == last_idx);

    assign tx_data   = resp[{idx, 3'b000} +: 8];
    assign mem_addr  = addr;
    assign mem_wdata = wdata;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        err_next   = 1'b0;
        case (state)
            IDLE: begin
                if (rx_data_fresh) begin
                    if (rx_data == OP_WRITE || rx_data == OP_READ) begin
                        state_next = ADDR;
                    end else begin
                        state_next = RESP;
                        err_next   = 1'b1;
                    end
                end
            end
            ADDR: begin
                if (rx_data_fresh) begin
                    if (cnt == LAST_ADDR) state_next = (op == OP_WRITE) ? DATA : BUS;
                end else if (timeout_hit) begin
                    state_next = IDLE;
                    err_next   = 1'b1;
                end
            end
            DATA: begin
                if (rx_data_fresh) begin
                    if (cnt == 3'd3) state_next = BUS;
                end else if (timeout_hit) begin
                    state_next = IDLE;
                    err_next   = 1'b1;
                end
            end
            BUS: begin
                if (bus_done)      state_next = RESP;
                if (rx_data_fresh) err_next   = 1'b1;
            end
            RESP: begin
                if (tx_done)       state_next = IDLE;
                if (rx_data_fresh) err_next   = 1'b1;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op            <= '0;
            cnt           <= '0;
            tmo           <= '0;
            addr          <= '0;
            wdata         <= '0;
            resp          <= '0;
            idx           <= '0;
            last_idx      <= '0;
            mem_req       <= 1'b0;
            mem_we        <= 1'b0;
            tx_data_valid <= 1'b0;
            err_pulse     <= 1'b0;
        end else begin
            err_pulse <= err_next;

            if (state_next != state)            cnt <= '0;
            else if (rx_data_fresh && in_frame) cnt <= cnt + 3'd1;

            // Down-counter reloads on every byte and whenever no frame is open.
            if (rx_data_fresh || !in_frame) tmo <= TMO_LOAD;
            else if (tmo != '0)             tmo <= tmo - TMO_W'(1);

            if (state == IDLE && rx_data_fresh) op <= rx_data;
            if (state == ADDR && rx_data_fresh) addr[{cnt, 3'b000} +: 8] <= rx_data;
            if (state == DATA && rx_data_fresh) wdata[{cnt[1:0], 3'b000} +: 8] <= rx_data;

            if (state != BUS && state_next == BUS) begin
                mem_req <= 1'b1;
                mem_we  <= (op == OP_WRITE);
            end else if (bus_done) begin
                mem_req <= 1'b0;
            end

            if (state == IDLE && state_next == RESP) begin
                resp     <= {24'd0, RSP_NAK};
                last_idx <= 2'd0;
            end else if (bus_done) begin
                resp     <= mem_we ? {24'd0, RSP_ACK} : mem_rdata;
                last_idx <= mem_we ? 2'd0 : 2'd3;
            end

            if (state != RESP)                      idx <= '0;
            else if (tx_data_valid && tx_data_ack) idx <= idx + 2'd1;

            // Valid drops for one cycle after each accepted byte.
            if (state != RESP)                      tx_data_valid <= (state_next == RESP);
            else if (tx_data_valid && tx_data_ack) tx_data_valid <= 1'b0;
            else                                    tx_data_valid <= 1'b1;
        end
    end

endmodule

// File: tb/tb_uart_cmd_responder.sv
// Scoreboard bench for uart_cmd_responder: bus and tx responders pop expectations
// pushed by the frame-sending tasks.
module tb_uart_cmd_responder;
    import uart_bridge_pkg::*;

    localparam int TIMEOUT_CYCLES = 100;
    localparam int ADDR_W         = 32;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic [7:0]        rx_data = 8'h00;
    logic              rx_data_fresh = 1'b0;
    logic [7:0]        tx_data;
    logic              tx_data_valid;
    logic              tx_data_ack;
    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic [31:0]       mem_rdata;
    logic              mem_ready;
    logic              err_pulse;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
    } mem_exp_t;

    mem_exp_t    exp_mem[$];
    logic [7:0]  exp_tx[$];
    logic [31:0] mem_model[logic [31:0]];

    int   n_checks = 0;
    int   n_errors = 0;
    int   err_seen = 0;
    int   req_count = 0;
    logic req_prev = 1'b0;
    int   mem_lat = 0;
    int   tx_lat_min = 0;
    int   tx_lat_max = 2;

    always #5 clk = ~clk;

    uart_cmd_responder #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES),
        .ADDR_W        (ADDR_W)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .rx_data      (rx_data),
        .rx_data_fresh(rx_data_fresh),
        .tx_data      (tx_data),
        .tx_data_valid(tx_data_valid),
        .tx_data_ack  (tx_data_ack),
        .mem_req      (mem_req),
        .mem_we       (mem_we),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .mem_rdata    (mem_rdata),
        .mem_ready    (mem_ready),
        .err_pulse    (err_pulse)
    );

    always @(negedge clk) begin
        if (err_pulse) err_seen++;
        if (mem_req && !req_prev) req_count++;
        req_prev = mem_req;
    end

    initial begin : mem_responder
        mem_exp_t    e;
        logic [31:0] rd;
        int          k;
        mem_ready = 1'b0;
        mem_rdata = 32'h0;
        forever begin
            @(negedge clk);
            if (rst_n && mem_req) begin
                n_checks++;
                if (exp_mem.size() == 0) begin
                    e = '{we: 1'b0, addr: 32'h0, wdata: 32'h0};
                    n_errors++;
                    $display("FAIL mem_unexpected: got req we=%b addr=%h, required no access", mem_we, mem_addr);
                end else begin
                    e = exp_mem.pop_front();
                    if (mem_we !== e.we || mem_addr !== e.addr || (e.we && mem_wdata !== e.wdata)) begin
                        n_errors++;
                        $display("FAIL mem_access: got we=%b addr=%h wdata=%h, required we=%b addr=%h wdata=%h",
                                 mem_we, mem_addr, mem_wdata, e.we, e.addr, e.wdata);
                    end
                end
                k = 0;
                while (k < mem_lat && rst_n) begin
                    @(negedge clk);
                    k++;
                    if (rst_n) begin
                        n_checks++;
                        if (mem_req !== 1'b1 || mem_addr !== e.addr || mem_we !== e.we) begin
                            n_errors++;
                            $display("FAIL mem_hold: got req=%b addr=%h we=%b, required req=1 addr=%h we=%b",
                                     mem_req, mem_addr, mem_we, e.addr, e.we);
                        end
                    end
                end
                if (rst_n) begin
                    rd = mem_model.exists(e.addr) ? mem_model[e.addr] : (e.addr ^ 32'hA5A5_5A5A);
                    if (e.we) mem_model[e.addr] = e.wdata;
                    else for (int b = 0; b < 4; b++) exp_tx.push_back(rd[8*b +: 8]);
                    mem_rdata = e.we ? 32'hFFFF_FFFF : rd;
                    mem_ready = 1'b1;
                    @(negedge clk);
                    mem_ready = 1'b0;
                    mem_rdata = 32'h0;
                    n_checks++;
                    if (mem_req !== 1'b0 || tx_data_valid !== 1'b1) begin
                        n_errors++;
                        $display("FAIL mem_done: got req=%b tx_valid=%b, required req=0 tx_valid=1",
                                 mem_req, tx_data_valid);
                    end
                end
            end
        end
    end

    initial begin : tx_sink
        logic [7:0] want;
        int         d;
        tx_data_ack = 1'b0;
        forever begin
            @(negedge clk);
            if (rst_n && tx_data_valid) begin
                n_checks++;
                if (exp_tx.size() == 0) begin
                    want = 8'h00;
                    n_errors++;
                    $display("FAIL tx_unexpected: got byte %h, required no byte", tx_data);
                end else begin
                    want = exp_tx.pop_front();
                    if (tx_data !== want) begin
                        n_errors++;
                        $display("FAIL tx_byte: got %h, required %h", tx_data, want);
                    end
                end
                d = $urandom_range(tx_lat_max, tx_lat_min);
                for (int i = 0; i < d; i++) begin
                    @(negedge clk);
                    if (!rst_n) break;
                    n_checks++;
                    if (tx_data_valid !== 1'b1 || tx_data !== want) begin
                        n_errors++;
                        $display("FAIL tx_hold: got valid=%b byte=%h, required valid=1 byte=%h",
                                 tx_data_valid, tx_data, want);
                    end
                end
                if (rst_n) begin
                    tx_data_ack = 1'b1;
                    @(negedge clk);
                    tx_data_ack = 1'b0;
                    n_checks++;
                    if (tx_data_valid !== 1'b0) begin
                        n_errors++;
                        $display("FAIL tx_after_ack: got valid=%b, required 0", tx_data_valid);
                    end
                end
            end
        end
    end

    task automatic send_byte(input logic [7:0] b, input int gap);
        repeat (gap) @(negedge clk);
        rx_data       = b;
        rx_data_fresh = 1'b1;
        @(negedge clk);
        rx_data_fresh = 1'b0;
    endtask

    task automatic write_frame(input logic [31:0] addr, input logic [31:0] data, input int gap);
        exp_mem.push_back('{we: 1'b1, addr: addr, wdata: data});
        exp_tx.push_back(RSP_ACK);
        send_byte(OP_WRITE, 0);
        for (int i = 0; i < 4; i++) send_byte(addr[8*i +: 8], gap);
        for (int i = 0; i < 4; i++) send_byte(data[8*i +: 8], gap);
    endtask

    task automatic read_frame(input logic [31:0] addr, input int gap);
        exp_mem.push_back('{we: 1'b0, addr: addr, wdata: 32'h0});
        send_byte(OP_READ, 0);
        for (int i = 0; i < 4; i++) send_byte(addr[8*i +: 8], gap);
    endtask

    task automatic wait_idle(input string name);
        int k = 0;
        while (k < 500 && (exp_tx.size() != 0 || exp_mem.size() != 0 || tx_data_valid || mem_req)) begin
            @(negedge clk);
            k++;
        end
        repeat (3) @(negedge clk);
        n_checks++;
        if (k >= 500) begin
            n_errors++;
            $display("FAIL %s_idle: still busy after %0d cycles, tx_pending=%0d mem_pending=%0d, required 0",
                     name, k, exp_tx.size(), exp_mem.size());
        end
    endtask

    task automatic test_reset();
        @(negedge clk);
        n_checks++;
        if ({tx_data_valid, mem_req, mem_we, err_pulse} !== 4'b0 || tx_data !== 8'h0) begin
            n_errors++;
            $display("FAIL reset_ctrl: got valid=%b req=%b we=%b err=%b tx=%h, required all 0",
                     tx_data_valid, mem_req, mem_we, err_pulse, tx_data);
        end
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        n_checks++;
        if (mem_addr !== 32'h0 || mem_wdata !== 32'h0 || tx_data_valid !== 1'b0 || mem_req !== 1'b0) begin
            n_errors++;
            $display("FAIL reset_data: got addr=%h wdata=%h valid=%b req=%b, required all 0",
                     mem_addr, mem_wdata, tx_data_valid, mem_req);
        end
    endtask

    task automatic test_write();
        int r0 = req_count;
        mem_lat = 0;
        write_frame(32'h8000_0010, 32'hDEAD_BEEF, 0);
        n_checks++;
        if (mem_req !== 1'b1) begin
            n_errors++;
            $display("FAIL write_latency: got mem_req=%b one cycle after last byte, required 1", mem_req);
        end
        wait_idle("write");
        n_checks++;
        if (req_count !== r0 + 1) begin
            n_errors++;
            $display("FAIL write_req_count: got %0d requests, required 1", req_count - r0);
        end
    endtask

    task automatic test_read();
        mem_lat    = 3;
        tx_lat_max = 3;
        read_frame(32'h0000_0004, 0);
        wait_idle("read");
        mem_lat    = 0;
        tx_lat_max = 2;
    endtask

    task automatic test_bad_opcode();
        int e0 = err_seen;
        int r0 = req_count;
        exp_tx.push_back(RSP_NAK);
        send_byte(8'h41, 0);
        wait_idle("bad_op");
        n_checks++;
        if (err_seen !== e0 + 1 || req_count !== r0) begin
            n_errors++;
            $display("FAIL bad_op_err: got err=%0d req=%0d, required err=1 req=0", err_seen - e0, req_count - r0);
        end
        read_frame(32'h0000_0100, 2);
        wait_idle("bad_op_read");
    endtask

    task automatic test_timeout();
        int e0 = err_seen;
        int r0 = req_count;
        int i;
        send_byte(OP_WRITE, 0);
        send_byte(8'h10, 0);
        send_byte(8'h00, 0);
        for (i = 1; i <= 150; i++) begin
            @(negedge clk);
            if (err_pulse) break;
        end
        n_checks++;
        if (i !== TIMEOUT_CYCLES) begin
            n_errors++;
            $display("FAIL timeout_cycle: err_pulse after %0d cycles, required %0d", i, TIMEOUT_CYCLES);
        end
        wait_idle("timeout");
        n_checks++;
        if (err_seen !== e0 + 1 || req_count !== r0) begin
            n_errors++;
            $display("FAIL timeout_err: got err=%0d req=%0d, required err=1 req=0", err_seen - e0, req_count - r0);
        end
        write_frame(32'h0000_0020, 32'hCAFE_F00D, 1);
        wait_idle("timeout_write");
        read_frame(32'h0000_0020, 0);
        wait_idle("timeout_read");
    endtask

    task automatic test_timeout_boundary();
        int e0 = err_seen;
        read_frame(32'h0000_0040, TIMEOUT_CYCLES - 1);
        wait_idle("boundary");
        n_checks++;
        if (err_seen !== e0) begin
            n_errors++;
            $display("FAIL boundary_err: got %0d err pulses, required 0", err_seen - e0);
        end
    endtask

    task automatic test_drop();
        int e0 = err_seen;
        int k  = 0;
        tx_lat_min = 6;
        tx_lat_max = 6;
        write_frame(32'h0000_0030, 32'h0BAD_F00D, 0);
        while (!tx_data_valid && k < 20) begin
            @(negedge clk);
            k++;
        end
        n_checks++;
        if (k >= 20) begin
            n_errors++;
            $display("FAIL drop_wait: tx_data_valid=%b after %0d cycles, required 1", tx_data_valid, k);
        end
        send_byte(8'h33, 0);
        wait_idle("drop");
        n_checks++;
        if (err_seen !== e0 + 1) begin
            n_errors++;
            $display("FAIL drop_err: got %0d err pulses, required 1", err_seen - e0);
        end
        tx_lat_min = 0;
        tx_lat_max = 2;
        read_frame(32'h0000_0030, 0);
        wait_idle("drop_read");
    endtask

    task automatic test_back_to_back();
        logic [31:0] a;
        for (int i = 0; i < 3; i++) begin
            a = 32'h1000_0000 + 32'(i * 4);
            write_frame(a, 32'h5A00_0000 | 32'(i * 32'h0101), 0);
            wait_idle("b2b_write");
            read_frame(a, 0);
            wait_idle("b2b_read");
        end
    endtask

    task automatic test_async_reset();
        int r0 = req_count;
        mem_lat = 1000;
        read_frame(32'h0000_0050, 0);
        repeat (2) @(negedge clk);
        n_checks++;
        if (mem_req !== 1'b1) begin
            n_errors++;
            $display("FAIL areset_pre: got mem_req=%b, required 1", mem_req);
        end
        #2 rst_n = 1'b0;
        #1;
        n_checks++;
        if (mem_req !== 1'b0 || tx_data_valid !== 1'b0) begin
            n_errors++;
            $display("FAIL areset_async: got req=%b valid=%b, required 0 and 0", mem_req, tx_data_valid);
        end
        repeat (2) @(negedge clk);
        rst_n   = 1'b1;
        mem_lat = 0;
        n_checks++;
        if (exp_mem.size() !== 0 || req_count !== r0 + 1) begin
            n_errors++;
            $display("FAIL areset_bus: got pending=%0d req=%0d, required 0 and 1", exp_mem.size(), req_count - r0);
        end
        write_frame(32'h0000_0060, 32'h1357_9BDF, 0);
        wait_idle("areset_write");
        read_frame(32'h0000_0060, 0);
        wait_idle("areset_read");
    endtask

    initial begin
        mem_model[32'h0000_0004] = 32'h1234_5678;
        test_reset();
        test_write();
        test_read();
        test_bad_opcode();
        test_timeout();
        test_timeout_boundary();
        test_drop();
        test_back_to_back();
        test_async_reset();
        n_checks++;
        if (exp_tx.size() !== 0 || exp_mem.size() !== 0) begin
            n_errors++;
            $display("FAIL drain: got tx_pending=%0d mem_pending=%0d, required 0", exp_tx.size(), exp_mem.size());
        end
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #1_000_000;
        n_errors++;
        $display("FAIL watchdog: time limit reached, required completion");
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $fatal(1, "watchdog");
    end

endmodule
